ahb_arb2: RTL and testbench
===========================

AHB_ARB2 -- requirements
Module: ahb_arb2

Interface
REQ-001 SHALL have parameter RR_EN, default 1, arbitration mode: 1 round-robin, 0 fixed priority with m1 winning.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports m0_haddr, m1_haddr  input  32  master address.
REQ-005 SHALL have ports m0_htrans, m1_htrans  input  2  master transfer type; bit1=1 is a request.
REQ-006 SHALL have ports m0_hwrite, m1_hwrite  input  1  master write flag.
REQ-007 SHALL have ports m0_hsize, m1_hsize  input  3  master transfer size.
REQ-008 SHALL have ports m0_hwdata, m1_hwdata  input  64  master write data.
REQ-009 SHALL have ports m0_hready, m1_hready  output  1  per-master ready.
REQ-010 SHALL have ports m0_hrdata, m1_hrdata  output  64  read data; both equal s_hrdata.
REQ-011 SHALL have ports m0_hresp, m1_hresp  output  1  per-master error response.
REQ-012 SHALL have ports s_haddr 32, s_htrans 2, s_hwrite 1, s_hsize 3, s_hwdata 64, all outputs to the shared slave.
REQ-013 SHALL have ports s_hrdata 64, s_hready 1, s_hresp 1, all inputs from the shared slave.

Function
REQ-014 SHALL capture master N's request into pending register pN (addr, write, size) at any edge where mN_htrans[1]=1 and mN_hready=1.
REQ-015 SHALL treat SEQ as NONSEQ; s_htrans is only 2'b10 or 2'b00; bursts are not supported.
REQ-016 SHALL drive mN_hready=0 from capture until N's data phase completes, giving one outstanding transfer per master.
REQ-017 SHALL drive mN_hready = (no pending, no address or data phase for N) OR (dp_owner==N AND s_hready), combinationally.
REQ-018 SHALL select the address-phase master combinationally when unlocked: single pending wins; if both are pending, RR_EN=1 picks the master not in last_grant and RR_EN=0 picks m1.
REQ-019 SHALL lock the selection while s_htrans=NONSEQ and s_hready=0; s_haddr, s_hwrite and s_hsize stay stable until s_hready=1.
REQ-020 SHALL drive s_haddr, s_hwrite and s_hsize from the selected pending register and s_htrans=2'b10 while any pending exists, else 2'b00.
REQ-021 SHALL, at an edge with s_htrans=NONSEQ and s_hready=1, clear the selected pending, set dp_owner to it, and set last_grant to it.
REQ-022 SHALL clear dp_owner to NONE at an edge with s_hready=1 and no address accepted.
REQ-023 SHALL drive s_hwdata = hwdata of dp_owner, else 0.
REQ-024 SHALL drive mN_hresp = s_hresp when dp_owner==N, else 0.
REQ-025 SHALL overlap an address phase of one master with the data phase of the other, giving back-to-back transfers at one per cycle with zero-wait slave.
REQ-026 SHALL drive s_htrans=2'b00 in the first error cycle (s_hresp=1, s_hready=0); pendings are retained and reissued afterwards.
REQ-027 SHALL have minimum latency: capture at cycle 0, slave address phase cycle 1, data phase and mN_hready=1 in cycle 2.
REQ-028 SHALL treat a capture and a completion for the same master in the same cycle as completion of the old transfer then capture of the new.

Reset
REQ-029 SHALL, on any edge with rst=1, clear p0/p1, dp_owner=NONE, lock=0, last_grant=m1.
REQ-030 SHALL, in the cycle after rst, drive s_htrans=00, m0_hready=m1_hready=1, m0_hresp=m1_hresp=0, s_hwdata=0.
REQ-031 SHALL, when rst asserts mid-transfer, drop that transfer without a response to the master.

Verification
REQ-032 SHALL cover: m0 write 0x80000010, hwdata 0x1122334455667788, s_hready=1 -> cycle1 s_haddr=0x80000010, s_htrans=10, s_hwrite=1; cycle2 s_hwdata=0x1122334455667788, m0_hready=1.
REQ-033 SHALL cover: RR_EN=1, after reset, m0 read 0x80000000 and m1 write 0xD0580000 in the same cycle -> m0 address cycle1, m1 address cycle2 overlapping m0 data, m1_hready=1 cycle3.
REQ-034 SHALL cover: RR_EN=0 with the same stimulus -> m1 address cycle1, m0 address cycle2.
REQ-035 SHALL cover: s_hready=0 for 3 cycles during m0 address phase, m1 request arrives -> s_haddr held at m0 value, no switch, m1 issued after the stall.
REQ-036 SHALL cover: m1 data phase gets s_hresp=1/s_hready=0 then s_hresp=1/s_hready=1 -> m1_hresp=1 both cycles, m1_hready 0 then 1, s_htrans=00 in the first error cycle.
REQ-037 SHALL cover: rst=1 for 1 cycle during m0 data phase with m1 pending -> next cycle s_htrans=00, both hready=1, no later transfer for m1.

Source files
------------

// File: rtl/ahb_arb2.sv
// Two-master to one-slave AHB-Lite arbiter with pending-request capture and
// overlapped address/data phases (single transfers only, no bursts).
module ahb_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [63:0] m0_hwdata,
  output logic        m0_hready,
  output logic [63:0] m0_hrdata,
  output logic        m0_hresp,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [63:0] m1_hwdata,
  output logic        m1_hready,
  output logic [63:0] m1_hrdata,
  output logic        m1_hresp,
  output logic [31:0] s_haddr,
  output logic [1:0]  s_htrans,
  output logic        s_hwrite,
  output logic [2:0]  s_hsize,
  output logic [63:0] s_hwdata,
  input  logic [63:0] s_hrdata,
  input  logic        s_hready,
  input  logic        s_hresp
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIZE_W = 3;
  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [SIZE_W-1:0] size;
  } pend_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_e;

  pend_t p0_q, p1_q, sel_p;
  logic  p0_v, p1_v;
  own_e  dp_owner;
  logic  lock_q, sel_q, last_grant;
  logic  sel_c, accept_c, err_first_c, cap0_c, cap1_c;
  logic  unused_htrans;

  assign unused_htrans = ^{m0_htrans[0], m1_htrans[0]};

  // Address-phase master: held while a stalled NONSEQ is on the bus
  always_comb begin
    sel_c = 1'b0;
    if (lock_q)
      sel_c = sel_q;
    else if (p0_v && p1_v)
      sel_c = RR_EN ? ~last_grant : 1'b1;
    else if (p1_v)
      sel_c = 1'b1;
  end

  // First error cycle forces IDLE so the retained pending is reissued later
  assign err_first_c = s_hresp && !s_hready;
  assign sel_p       = sel_c ? p1_q : p0_q;
  assign s_htrans    = ((p0_v || p1_v) && !err_first_c) ? HT_NONSEQ : HT_IDLE;
  assign s_haddr     = sel_p.addr;
  assign s_hwrite    = sel_p.write;
  assign s_hsize     = sel_p.size;
  assign accept_c    = s_htrans[1] && s_hready;

  assign m0_hready = (!p0_v && (dp_owner != OWN_M0)) || ((dp_owner == OWN_M0) && s_hready);
  assign m1_hready = (!p1_v && (dp_owner != OWN_M1)) || ((dp_owner == OWN_M1) && s_hready);
  assign m0_hresp  = (dp_owner == OWN_M0) && s_hresp;
  assign m1_hresp  = (dp_owner == OWN_M1) && s_hresp;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign cap0_c    = m0_htrans[1] && m0_hready;
  assign cap1_c    = m1_htrans[1] && m1_hready;

  always_comb begin
    s_hwdata = DATA_W'(0);
    case (dp_owner)
      OWN_M0:  s_hwdata = m0_hwdata;
      OWN_M1:  s_hwdata = m1_hwdata;
      default: s_hwdata = DATA_W'(0);
    endcase
  end

  // Clear-on-accept precedes capture so a completing master can requeue at once
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_v       <= 1'b0;
      p1_v       <= 1'b0;
      p0_q       <= '0;
      p1_q       <= '0;
      dp_owner   <= OWN_NONE;
      lock_q     <= 1'b0;
      sel_q      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      lock_q <= s_htrans[1] && !s_hready;
      sel_q  <= sel_c;
      if (accept_c) begin
        dp_owner   <= sel_c ? OWN_M1 : OWN_M0;
        last_grant <= sel_c;
        if (sel_c) p1_v <= 1'b0;
        else       p0_v <= 1'b0;
      end else if (s_hready) begin
        dp_owner <= OWN_NONE;
      end
      if (cap0_c) begin
        p0_v <= 1'b1;
        p0_q <= '{addr: m0_haddr, write: m0_hwrite, size: m0_hsize};
      end
      if (cap1_c) begin
        p1_v <= 1'b1;
        p1_q <= '{addr: m1_haddr, write: m1_hwrite, size: m1_hsize};
      end
    end
  end

endmodule

// File: tb/tb_ahb_arb2.sv
// Scoreboard bench for ahb_arb2: a round-robin and a fixed-priority instance
// share stimulus; cycle-stamped expectations are consumed by a monitor.
module tb_ahb_arb2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_haddr = '0, m1_haddr = '0;
  logic [1:0]  m0_htrans = '0, m1_htrans = '0;
  logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
  logic [2:0]  m0_hsize = '0, m1_hsize = '0;
  logic [63:0] m0_hwdata = '0, m1_hwdata = '0;
  logic [63:0] s_hrdata = 64'hCAFE_F00D_0BAD_BEEF;
  logic        s_hready = 1'b1, s_hresp = 1'b0;

  logic        rr_m0_hready, rr_m1_hready, rr_m0_hresp, rr_m1_hresp, rr_s_hwrite;
  logic [63:0] rr_m0_hrdata, rr_m1_hrdata, rr_s_hwdata;
  logic [31:0] rr_s_haddr;
  logic [1:0]  rr_s_htrans;
  logic [2:0]  rr_s_hsize;
  logic        fp_m0_hready, fp_m1_hready, fp_m0_hresp, fp_m1_hresp, fp_s_hwrite;
  logic [63:0] fp_m0_hrdata, fp_m1_hrdata, fp_s_hwdata;
  logic [31:0] fp_s_haddr;
  logic [1:0]  fp_s_htrans;
  logic [2:0]  fp_s_hsize;

  ahb_arb2 #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hwdata(m0_hwdata), .m0_hready(rr_m0_hready), .m0_hrdata(rr_m0_hrdata), .m0_hresp(rr_m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hwdata(m1_hwdata), .m1_hready(rr_m1_hready), .m1_hrdata(rr_m1_hrdata), .m1_hresp(rr_m1_hresp),
    .s_haddr(rr_s_haddr), .s_htrans(rr_s_htrans), .s_hwrite(rr_s_hwrite), .s_hsize(rr_s_hsize),
    .s_hwdata(rr_s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  ahb_arb2 #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hwdata(m0_hwdata), .m0_hready(fp_m0_hready), .m0_hrdata(fp_m0_hrdata), .m0_hresp(fp_m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hwdata(m1_hwdata), .m1_hready(fp_m1_hready), .m1_hrdata(fp_m1_hrdata), .m1_hresp(fp_m1_hresp),
    .s_haddr(fp_s_haddr), .s_htrans(fp_s_htrans), .s_hwrite(fp_s_hwrite), .s_hsize(fp_s_hsize),
    .s_hwdata(fp_s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_HTRANS = 0, S_HADDR = 1, S_HWRITE = 2, S_HSIZE = 3, S_HWDATA = 4;
  localparam int M0_RDY = 5, M1_RDY = 6, M0_RESP = 7, M1_RESP = 8, M0_RDATA = 9, M1_RDATA = 10;

  typedef struct {
    int          cyc;
    int          inst;
    int          id;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [63:0] obs(input int inst, input int id);
    logic [63:0] r;
    r = '0;
    case (id)
      S_HTRANS: r = 64'(inst == 0 ? rr_s_htrans : fp_s_htrans);
      S_HADDR:  r = 64'(inst == 0 ? rr_s_haddr  : fp_s_haddr);
      S_HWRITE: r = 64'(inst == 0 ? rr_s_hwrite : fp_s_hwrite);
      S_HSIZE:  r = 64'(inst == 0 ? rr_s_hsize  : fp_s_hsize);
      S_HWDATA: r = inst == 0 ? rr_s_hwdata : fp_s_hwdata;
      M0_RDY:   r = 64'(inst == 0 ? rr_m0_hready : fp_m0_hready);
      M1_RDY:   r = 64'(inst == 0 ? rr_m1_hready : fp_m1_hready);
      M0_RESP:  r = 64'(inst == 0 ? rr_m0_hresp  : fp_m0_hresp);
      M1_RESP:  r = 64'(inst == 0 ? rr_m1_hresp  : fp_m1_hresp);
      M0_RDATA: r = inst == 0 ? rr_m0_hrdata : fp_m0_hrdata;
      M1_RDATA: r = inst == 0 ? rr_m1_hrdata : fp_m1_hrdata;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Expectation for the current cycle on one instance (0 = round-robin, 1 = fixed)
  task automatic exp_on(input int inst, input int id, input logic [63:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.inst = inst; e.id = id; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_both(input int id, input logic [63:0] v, input string name);
    exp_on(0, id, v, name);
    exp_on(1, id, v, name);
  endtask

  // Monitor: consume every expectation stamped with the current cycle
  always @(negedge clk) begin
    int i;
    logic [63:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        got = obs(sb[i].inst, sb[i].id);
        n_cmp++;
        if (got !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s inst%0d cyc%0d: got 0x%0h expected 0x%0h",
                   sb[i].name, sb[i].inst, cyc, got, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s inst%0d: expectation for cyc%0d never sampled", sb[i].name, sb[i].inst, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic w, input logic [63:0] d);
    if (m == 0) begin
      m0_htrans = 2'b10; m0_haddr = a; m0_hwrite = w; m0_hsize = 3'd3; m0_hwdata = d;
    end else begin
      m1_htrans = 2'b10; m1_haddr = a; m1_hwrite = w; m1_hsize = 3'd3; m1_hwdata = d;
    end
  endtask

  task automatic idle_cycles(input int n);
    m0_htrans = 2'b00; m1_htrans = 2'b00; s_hready = 1'b1; s_hresp = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    do_reset();
    exp_both(S_HTRANS, 64'd0, "rst_htrans");
    exp_both(M0_RDY,   64'd1, "rst_m0_hready");
    exp_both(M1_RDY,   64'd1, "rst_m1_hready");
    exp_both(M0_RESP,  64'd0, "rst_m0_hresp");
    exp_both(M1_RESP,  64'd0, "rst_m1_hresp");
    exp_both(S_HWDATA, 64'd0, "rst_hwdata");
    tick();

    // Single write, minimum latency
    req(0, 32'h8000_0010, 1'b1, 64'h1122_3344_5566_7788);
    exp_both(M0_RDY, 64'd1, "t1_capture_rdy");
    tick();
    m0_htrans = 2'b00;
    exp_both(S_HTRANS, 64'd2, "t1_htrans");
    exp_both(S_HADDR,  64'h8000_0010, "t1_haddr");
    exp_both(S_HWRITE, 64'd1, "t1_hwrite");
    exp_both(S_HSIZE,  64'd3, "t1_hsize");
    exp_both(M0_RDY,   64'd0, "t1_wait_rdy");
    exp_both(M1_RDY,   64'd1, "t1_m1_idle_rdy");
    tick();
    exp_both(S_HWDATA, 64'h1122_3344_5566_7788, "t1_hwdata");
    exp_both(M0_RDY,   64'd1, "t1_done_rdy");
    exp_both(S_HTRANS, 64'd0, "t1_idle_after");
    exp_both(M0_RDATA, 64'hCAFE_F00D_0BAD_BEEF, "t1_m0_hrdata");
    exp_both(M1_RDATA, 64'hCAFE_F00D_0BAD_BEEF, "t1_m1_hrdata");
    idle_cycles(2);

    // Simultaneous requests after reset: round-robin vs fixed priority
    do_reset();
    tick();
    req(0, 32'h8000_0000, 1'b0, 64'hAAAA_0000_0000_0001);
    req(1, 32'hD058_0000, 1'b1, 64'hDDDD_0000_0000_0002);
    tick();
    m0_htrans = 2'b00; m1_htrans = 2'b00;
    exp_on(0, S_HADDR,  64'h8000_0000, "rr_c1_haddr");
    exp_on(0, S_HWRITE, 64'd0, "rr_c1_hwrite");
    exp_on(0, S_HTRANS, 64'd2, "rr_c1_htrans");
    exp_on(1, S_HADDR,  64'hD058_0000, "fp_c1_haddr");
    exp_on(1, S_HWRITE, 64'd1, "fp_c1_hwrite");
    tick();
    exp_on(0, S_HADDR,  64'hD058_0000, "rr_c2_haddr");
    exp_on(0, S_HTRANS, 64'd2, "rr_c2_htrans");
    exp_on(0, M0_RDY,   64'd1, "rr_c2_m0_rdy");
    exp_on(0, M1_RDY,   64'd0, "rr_c2_m1_rdy");
    exp_on(0, S_HWDATA, 64'hAAAA_0000_0000_0001, "rr_c2_hwdata");
    exp_on(1, S_HADDR,  64'h8000_0000, "fp_c2_haddr");
    exp_on(1, M1_RDY,   64'd1, "fp_c2_m1_rdy");
    exp_on(1, S_HWDATA, 64'hDDDD_0000_0000_0002, "fp_c2_hwdata");
    tick();
    exp_on(0, M1_RDY,   64'd1, "rr_c3_m1_rdy");
    exp_on(0, S_HWDATA, 64'hDDDD_0000_0000_0002, "rr_c3_hwdata");
    exp_on(0, S_HTRANS, 64'd0, "rr_c3_htrans");
    exp_on(1, M0_RDY,   64'd1, "fp_c3_m0_rdy");
    exp_on(1, S_HWDATA, 64'hAAAA_0000_0000_0001, "fp_c3_hwdata");
    idle_cycles(2);

    // Address-phase stall of m0 holds the bus while m1 request arrives
    req(0, 32'h8000_0100, 1'b0, 64'd0);
    exp_both(M0_RDY, 64'd1, "st_capture_rdy");
    tick();
    m0_htrans = 2'b00;
    s_hready = 1'b0;
    req(1, 32'h9000_0000, 1'b1, 64'h9999);
    exp_both(S_HADDR, 64'h8000_0100, "st_c1_haddr");
    exp_both(M1_RDY,  64'd1, "st_c1_m1_rdy");
    tick();
    m1_htrans = 2'b00;
    exp_both(S_HADDR, 64'h8000_0100, "st_c2_haddr");
    exp_both(M1_RDY,  64'd0, "st_c2_m1_rdy");
    exp_both(M0_RDY,  64'd0, "st_c2_m0_rdy");
    tick();
    exp_both(S_HADDR, 64'h8000_0100, "st_c3_haddr");
    tick();
    s_hready = 1'b1;
    exp_both(S_HADDR,  64'h8000_0100, "st_c4_haddr");
    exp_both(S_HTRANS, 64'd2, "st_c4_htrans");
    tick();
    exp_both(S_HADDR,  64'h9000_0000, "st_c5_haddr");
    exp_both(S_HWRITE, 64'd1, "st_c5_hwrite");
    exp_both(M0_RDY,   64'd1, "st_c5_m0_rdy");
    tick();
    exp_both(M1_RDY,   64'd1, "st_c6_m1_rdy");
    exp_both(S_HWDATA, 64'h9999, "st_c6_hwdata");
    idle_cycles(2);

    // Two-cycle error response on m1 data phase with m0 pending
    req(1, 32'hA000_0000, 1'b1, 64'h5555);
    tick();
    m1_htrans = 2'b00;
    req(0, 32'hA000_0040, 1'b0, 64'd0);
    exp_on(0, S_HADDR, 64'hA000_0000, "er_c1_haddr");
    exp_on(0, M0_RDY,  64'd1, "er_c1_m0_rdy");
    tick();
    m0_htrans = 2'b00;
    s_hresp = 1'b1; s_hready = 1'b0;
    exp_on(0, S_HTRANS, 64'd0, "er_c2_htrans");
    exp_on(0, M1_RESP,  64'd1, "er_c2_m1_hresp");
    exp_on(0, M1_RDY,   64'd0, "er_c2_m1_rdy");
    exp_on(0, M0_RESP,  64'd0, "er_c2_m0_hresp");
    exp_on(0, S_HWDATA, 64'h5555, "er_c2_hwdata");
    tick();
    s_hready = 1'b1;
    exp_on(0, M1_RESP,  64'd1, "er_c3_m1_hresp");
    exp_on(0, M1_RDY,   64'd1, "er_c3_m1_rdy");
    exp_on(0, S_HTRANS, 64'd2, "er_c3_htrans");
    exp_on(0, S_HADDR,  64'hA000_0040, "er_c3_haddr");
    tick();
    s_hresp = 1'b0;
    exp_on(0, M0_RDY,  64'd1, "er_c4_m0_rdy");
    exp_on(0, M1_RESP, 64'd0, "er_c4_m1_hresp");
    idle_cycles(2);

    // Completion and new capture for m0 in the same cycle
    req(0, 32'h8000_0200, 1'b1, 64'h7);
    tick();
    m0_htrans = 2'b00;
    exp_both(S_HADDR, 64'h8000_0200, "bb_c1_haddr");
    tick();
    req(0, 32'h8000_0300, 1'b1, 64'h7);
    exp_both(M0_RDY,   64'd1, "bb_c2_m0_rdy");
    exp_both(S_HWDATA, 64'h7, "bb_c2_hwdata");
    tick();
    m0_htrans = 2'b00; m0_hwdata = 64'h8;
    exp_both(S_HADDR,  64'h8000_0300, "bb_c3_haddr");
    exp_both(S_HTRANS, 64'd2, "bb_c3_htrans");
    exp_both(M0_RDY,   64'd0, "bb_c3_m0_rdy");
    tick();
    exp_both(M0_RDY,   64'd1, "bb_c4_m0_rdy");
    exp_both(S_HWDATA, 64'h8, "bb_c4_hwdata");
    idle_cycles(2);

    // Reset during m0 data phase with m1 pending drops everything
    req(0, 32'hB000_0000, 1'b1, 64'hB);
    tick();
    m0_htrans = 2'b00;
    req(1, 32'hC000_0000, 1'b1, 64'hC);
    tick();
    m1_htrans = 2'b00;
    s_hready = 1'b0;
    rst = 1'b1;
    exp_on(0, S_HADDR, 64'hC000_0000, "rs_c2_haddr");
    exp_on(0, M0_RDY,  64'd0, "rs_c2_m0_rdy");
    tick();
    rst = 1'b0; s_hready = 1'b1;
    exp_both(S_HTRANS, 64'd0, "rs_c3_htrans");
    exp_both(M0_RDY,   64'd1, "rs_c3_m0_rdy");
    exp_both(M1_RDY,   64'd1, "rs_c3_m1_rdy");
    exp_both(M0_RESP,  64'd0, "rs_c3_m0_hresp");
    exp_both(M1_RESP,  64'd0, "rs_c3_m1_hresp");
    exp_both(S_HWDATA, 64'd0, "rs_c3_hwdata");
    tick();
    exp_both(S_HTRANS, 64'd0, "rs_c4_htrans");
    tick();
    exp_both(S_HTRANS, 64'd0, "rs_c5_htrans");
    tick();

    // Drain: any expectation left after a bounded wait counts as failed
    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s inst%0d: expectation left unconsumed", sb[0].name, sb[0].inst);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
